c_reduce_bits_stream: RTL and testbench
=======================================

// Module: c_reduce_bits_stream
// PURPOSE
//  Time-domain counterpart of the spatial bit reducer: folds a multi-beat
//  message into one result bit per port, applying the selected binary op
//  across every bit of every beat in the message. Sits on the receive side of
//  multi-flit checks (parity/all-ones/any-set over a whole packet); presents
//  the result through a registered valid/ready output.
// PARAMETERS
//  num_ports  1                 number of independent lanes
//  width      32                bits per lane per beat
//  op         `BINARY_OP_AND    AND/NAND/OR/NOR/XOR/XNOR (c_constants.sv)
//  max_beats  16                max beats per message (>=2); cnt_width = clog2(max_beats+1)
// PORTS
//  clk         in   1                    clock
//  reset       in   1                    synchronous, active-high reset
//  in_valid    in   1                    beat present on data_in
//  in_last     in   1                    beat is final beat of message
//  in_ready    out  1                    block accepts beat this cycle
//  data_in     in   num_ports*width      beat data, port p at [p*width:(p+1)*width-1]
//  out_valid   out  1                    result held on data_out
//  out_ready   in   1                    consumer takes result
//  data_out    out  num_ports            per-port reduction over whole message
//  beat_count  out  cnt_width            beats in held message (valid with out_valid)
//  overflow    out  1                    held message hit max_beats without in_last
// BEHAVIOUR
//  - Beat accepted iff in_valid & in_ready; result handed off iff out_valid & out_ready.
//  - States: ACCUM (collecting, out_valid=0), HOLD (result held, out_valid=1).
//  - Reset: state=ACCUM, acc=identity, count=0, out_valid=0, data_out=0,
//    beat_count=0, overflow=0. Reset wins over any concurrent beat/handoff.
//  - Base op (AND/OR/XOR) accumulates; identity AND=1, OR=0, XOR=0. NAND/NOR/XNOR
//    invert the final value once at HOLD entry, never per beat.
//  - ACCUM: in_ready=1. Accepted beat: acc[p] = acc[p] base_op reduce(beat lane p),
//    count+1. If in_last, or count reaches max_beats: register final into
//    data_out, beat_count, overflow (=1 only if max_beats reached and !in_last),
//    go HOLD next cycle; acc=identity, count=0.
//  - Latency: data_out/out_valid assert the cycle after the terminating beat.
//  - HOLD: in_ready = out_ready (same-cycle drain and refill). On handoff without
//    new beat -> ACCUM, out_valid=0. On handoff with new beat: fold from identity;
//    single-beat message (in_last) stays HOLD with new result, else -> ACCUM.
//  - HOLD without out_ready: in_ready=0; data_out/beat_count/overflow stable.
//  - in_valid=0 in ACCUM: acc/count hold indefinitely (gaps allowed mid-message).
//  - data_out, beat_count, overflow are don't-care-free: all hold last value while
//    out_valid=0 after a handoff (no clearing) except at reset.
//  - Fully combinational in_ready path only through out_ready; no other comb paths
//    from inputs to outputs.
// TESTING (num_ports=2, width=4, max_beats=4 unless noted)
//  1 op=XOR, beats 0x3_1,0x0_1 (last) -> 1 cycle later out_valid, data_out=2'b00, beat_count=2
//  2 op=AND, beats 0xF_F,0xF_E(last) -> data_out=2'b10; op=NAND same -> 2'b01
//  3 op=OR, 4 beats 0x00 no in_last -> HOLD after 4th, overflow=1, beat_count=4, data_out=00
//  4 HOLD, out_ready=0 three cycles, in_valid=1 -> in_ready=0, outputs stable;
//    then out_ready=1 with single-beat 0xF_0 last (op=OR) -> next cycle data_out=2'b10, still out_valid
//  5 reset asserted mid-message after 2 beats -> next message of 1 beat reduces from identity,
//    beat_count=1; reset in HOLD -> out_valid=0 next cycle
//  6 random valid/ready gaps, all ops, 1000 msgs vs. reference model: zero mismatches, no lost/dup results

Source files
------------

// File: rtl/c_reduce_bits_stream.sv
// Purpose: fold every bit of every beat of a multi-beat message into one result bit per port.
// Latency: result and out_valid are registered; they appear the cycle after the terminating beat.
// Backpressure: in_ready=1 while collecting; while a result is held, in_ready follows out_ready.
//
// Op encoding: 0=AND 1=NAND 2=OR 3=NOR 4=XOR 5=XNOR.
// The inverting ops fold with their base op and invert once, when the result is captured.
module c_reduce_bits_stream #(
    parameter int num_ports = 1,
    parameter int width     = 32,
    parameter int op        = 0,
    parameter int max_beats = 16,
    localparam int cnt_width = $clog2(max_beats + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    input  logic [num_ports*width-1:0]   data_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [num_ports-1:0]         data_out,
    output logic [cnt_width-1:0]         beat_count,
    output logic                         overflow
);

    localparam int OP_AND  = 0;
    localparam int OP_NAND = 1;
    localparam int OP_OR   = 2;
    localparam int OP_NOR  = 3;
    localparam int OP_XOR  = 4;
    localparam int OP_XNOR = 5;

    localparam int BASE_AND = 0;
    localparam int BASE_OR  = 1;
    localparam int BASE_XOR = 2;

    // Base op used for folding; the inverting variants share the base op's accumulator.
    localparam int base_op = ((op == OP_AND) || (op == OP_NAND)) ? BASE_AND :
                             ((op == OP_OR)  || (op == OP_NOR))  ? BASE_OR  : BASE_XOR;
    localparam bit invert_result = (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    localparam bit identity_bit  = (base_op == BASE_AND);

    localparam logic [num_ports-1:0] acc_identity = {num_ports{identity_bit}};
    localparam logic [num_ports-1:0] out_invert   = {num_ports{invert_result}};
    localparam logic [cnt_width-1:0] max_cnt      = cnt_width'(max_beats);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [num_ports-1:0]   acc_q;
    logic [num_ports-1:0]   acc_fold;
    logic [num_ports-1:0]   lane_red;
    logic [cnt_width-1:0]   cnt_q;
    logic [cnt_width-1:0]   cnt_inc;
    logic                   hit_max;
    logic                   beat_take;
    logic                   handoff;
    logic                   terminate;

    // Reduce each port's lane of the current beat to a single bit with the base op.
    always_comb begin
        lane_red = '0;
        for (int p = 0; p < num_ports; p++) begin
            case (base_op)
                BASE_AND: lane_red[p] = &data_in[p*width +: width];
                BASE_OR:  lane_red[p] = |data_in[p*width +: width];
                default:  lane_red[p] = ^data_in[p*width +: width];
            endcase
        end
    end

    // Combine the running accumulator with the reduced beat.
    always_comb begin
        acc_fold = acc_q;
        case (base_op)
            BASE_AND: acc_fold = acc_q & lane_red;
            BASE_OR:  acc_fold = acc_q | lane_red;
            default:  acc_fold = acc_q ^ lane_red;
        endcase
    end

    // Only combinational input-to-output path: out_ready lets a held result drain and refill in one cycle.
    assign in_ready  = (state_q == ACCUM) | out_ready;

    assign cnt_inc   = cnt_q + cnt_width'(1);
    assign hit_max   = (cnt_inc == max_cnt);
    assign beat_take = in_valid & in_ready;
    assign handoff   = out_valid & out_ready;
    assign terminate = beat_take & (in_last | hit_max);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode: a terminating beat always lands in HOLD; a bare handoff returns to ACCUM.
    always_comb begin
        state_d   = state_q;
        out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                if (terminate) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (handoff) begin
                    state_d = terminate ? HOLD : ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // Accumulator, beat counter and captured result. The accumulator is back at identity whenever
    // a result is held, so a beat taken during a same-cycle refill folds from identity.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q      <= acc_identity;
            cnt_q      <= '0;
            data_out   <= '0;
            beat_count <= '0;
            overflow   <= 1'b0;
        end else if (beat_take) begin
            if (terminate) begin
                acc_q      <= acc_identity;
                cnt_q      <= '0;
                data_out   <= acc_fold ^ out_invert;
                beat_count <= cnt_inc;
                overflow   <= hit_max & ~in_last;
            end else begin
                acc_q      <= acc_fold;
                cnt_q      <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_c_reduce_bits_stream.sv
// Purpose: check c_reduce_bits_stream for all six ops in parallel (num_ports=2, width=4, max_beats=4).
// Latency: results are expected the cycle after the terminating beat.
// Backpressure: exercises stalls, same-cycle drain/refill, reset races and random valid/ready gaps.
module tb_c_reduce_bits_stream;

    localparam int NP  = 2;
    localparam int W   = 4;
    localparam int MB  = 4;
    localparam int CW  = 3;
    localparam int NOP = 6;
    localparam int NRAND = 1000;

    typedef logic [NOP-1:0][NP-1:0] res_t;   // index = op code

    typedef struct packed {
        logic [3:0][7:0] beats;
        logic [2:0]      n;
        logic            use_last;
        res_t            exp;
        logic            ovf;
    } vec_t;

    typedef struct packed {
        res_t       d;
        logic [2:0] bc;
        logic       ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_last;
    logic [NP*W-1:0]  data_in;
    logic             out_ready;
    logic             in_ready_a   [NOP];
    logic             out_valid_a  [NOP];
    logic [NP-1:0]    data_out_a   [NOP];
    logic [CW-1:0]    beat_count_a [NOP];
    logic             overflow_a   [NOP];

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs [6];
    exp_t exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NOP; g++) begin : g_dut
        c_reduce_bits_stream #(
            .num_ports (NP),
            .width     (W),
            .op        (g),
            .max_beats (MB)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid),
            .in_last    (in_last),
            .in_ready   (in_ready_a[g]),
            .data_in    (data_in),
            .out_valid  (out_valid_a[g]),
            .out_ready  (out_ready),
            .data_out   (data_out_a[g]),
            .beat_count (beat_count_a[g]),
            .overflow   (overflow_a[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Reference reduction over n beats, all six ops at once.
    function automatic res_t model(input logic [3:0][7:0] bts, input int n);
        res_t r;
        logic a, o, x;
        logic [3:0] ln;
        r = '0;
        for (int p = 0; p < NP; p++) begin
            a = 1'b1; o = 1'b0; x = 1'b0;
            for (int b = 0; b < n; b++) begin
                ln = bts[b][p*W +: W];
                a = a & (&ln);
                o = o | (|ln);
                x = x ^ (^ln);
            end
            r[0][p] = a;  r[1][p] = ~a;
            r[2][p] = o;  r[3][p] = ~o;
            r[4][p] = x;  r[5][p] = ~x;
        end
        return r;
    endfunction

    task automatic check_hold(input string tag, input res_t e, input int bc, input logic ovf);
        for (int i = 0; i < NOP; i++) begin
            chk($sformatf("%s valid op%0d", tag, i), 32'(out_valid_a[i]), 32'd1);
            chk($sformatf("%s result op%0d {data,cnt,ovf}", tag, i),
                32'({data_out_a[i], beat_count_a[i], overflow_a[i]}),
                32'({e[i], bc[2:0], ovf}));
        end
    endtask

    // Drive n beats back-to-back with out_ready low; returns half a cycle after the terminating edge.
    task automatic send_beats(input string tag, input logic [3:0][7:0] bts, input int n, input bit ul);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            data_in   = bts[b];
            in_last   = ul && (b == n - 1);
            out_ready = 1'b0;
            #4;
            if (b == n - 1) chk({tag, " no early valid"}, 32'(out_valid_a[0]), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
    endtask

    task automatic drain(input string tag, input res_t e);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk({tag, " valid drops"}, 32'(out_valid_a[0]), 32'd0);
        for (int i = 0; i < NOP; i++)
            chk($sformatf("%s data kept op%0d", tag, i), 32'(data_out_a[i]), 32'(e[i]));
    endtask

    task automatic set_vec(input int i, input logic [31:0] bts, input int n, input bit ul,
                           input res_t e, input logic ovf);
        vecs[i].beats    = bts;
        vecs[i].n        = n[2:0];
        vecs[i].use_last = ul;
        vecs[i].exp      = e;
        vecs[i].ovf      = ovf;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected results packed as {XNOR, XOR, NOR, OR, NAND, AND}, bit1 = port 1.
        set_vec(0, {16'h0, 8'h01, 8'h31}, 2, 1'b1, {2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00}, 1'b0);
        set_vec(1, {16'h0, 8'hFE, 8'hFF}, 2, 1'b1, {2'b10, 2'b01, 2'b00, 2'b11, 2'b01, 2'b10}, 1'b0);
        set_vec(2, 32'h0,                 4, 1'b0, {2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00}, 1'b1);
        set_vec(3, {24'h0, 8'hF0},        1, 1'b1, {2'b11, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10}, 1'b0);
        set_vec(4, {8'h00, 8'h8C, 8'h27, 8'h13}, 3, 1'b1, {2'b00, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00}, 1'b0);
        set_vec(5, {4{8'hFF}},            4, 1'b1, {2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11}, 1'b0);

        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; data_in = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < NOP; i++)
            chk($sformatf("reset state op%0d {rdy,vld,data,cnt,ovf}", i),
                32'({in_ready_a[i], out_valid_a[i], data_out_a[i], beat_count_a[i], overflow_a[i]}),
                32'({1'b1, 1'b0, 2'b00, 3'd0, 1'b0}));

        // Table-driven messages.
        for (int v = 0; v < 6; v++) begin
            send_beats($sformatf("vec%0d", v), vecs[v].beats, int'(vecs[v].n), vecs[v].use_last);
            check_hold($sformatf("vec%0d", v), vecs[v].exp, int'(vecs[v].n), vecs[v].ovf);
            drain($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Stalled HOLD, then same-cycle drain and single-beat refill.
        send_beats("stall", vecs[2].beats, 4, 1'b0);
        check_hold("stall entry", vecs[2].exp, 4, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; data_in = 8'hF0; in_last = 1'b1; out_ready = 1'b0;
            #4;
            chk($sformatf("stall%0d in_ready", k), 32'(in_ready_a[0]), 32'd0);
            check_hold($sformatf("stall%0d", k), vecs[2].exp, 4, 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #4;
        chk("refill in_ready", 32'(in_ready_a[0]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        #1;
        check_hold("refill single", vecs[3].exp, 1, 1'b0);

        // Drain with a non-final beat: must fall back to collecting, then finish the message.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; data_in = 8'hFF; in_last = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("refill multi valid low", 32'(out_valid_a[0]), 32'd0);
        send_beats("refill multi", {24'h0, 8'hFE}, 1, 1'b1);
        check_hold("refill multi", vecs[1].exp, 2, 1'b0);
        drain("refill multi", vecs[1].exp);

        // Reset mid-message, racing a terminating beat.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1; data_in = 8'h00; in_last = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b1; data_in = 8'h00; in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        #1;
        chk("reset beats terminating beat", 32'(out_valid_a[0]), 32'd0);
        send_beats("post reset", {24'h0, 8'hF0}, 1, 1'b1);
        check_hold("post reset", vecs[3].exp, 1, 1'b0);

        // Reset while holding.
        @(negedge clk);
        reset = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < NOP; i++)
            chk($sformatf("reset in hold op%0d {vld,data,cnt,ovf}", i),
                32'({out_valid_a[i], data_out_a[i], beat_count_a[i], overflow_a[i]}), 32'd0);

        // Random traffic against the reference model.
        begin
            int sent = 0, got = 0, cyc = 0, idx = 0, n = 0;
            bit have_msg = 1'b0, ul = 1'b0, took, hand;
            logic [3:0][7:0] bts = '0;
            exp_t e;
            while (got < NRAND && cyc < 40000) begin
                @(negedge clk);
                if (!have_msg && sent < NRAND) begin
                    n  = int'($urandom_range(1, 4));
                    ul = (n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
                    for (int b = 0; b < 4; b++) bts[b] = 8'($urandom);
                    idx = 0;
                    have_msg = 1'b1;
                end
                in_valid  = have_msg && ($urandom_range(0, 3) != 0);
                data_in   = bts[idx];
                in_last   = ul && (idx == n - 1);
                out_ready = ($urandom_range(0, 3) != 0);
                #4;
                took = in_valid & in_ready_a[0];
                hand = out_valid_a[0] & out_ready;
                if (hand) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL rand extra result: got a handoff, expected none pending");
                    end else begin
                        e = exp_q.pop_front();
                        for (int i = 0; i < NOP; i++)
                            chk($sformatf("rand msg%0d op%0d {data,cnt,ovf}", got, i),
                                32'({data_out_a[i], beat_count_a[i], overflow_a[i]}),
                                32'({e.d[i], e.bc, e.ovf}));
                    end
                    got++;
                end
                if (took) begin
                    idx++;
                    if (idx == n) begin
                        e.d   = model(bts, n);
                        e.bc  = n[2:0];
                        e.ovf = (n == MB) && !ul;
                        exp_q.push_back(e);
                        have_msg = 1'b0;
                        sent++;
                    end
                end
                @(posedge clk);
                cyc++;
            end
            chk("rand results received", 32'(got), 32'(NRAND));
            chk("rand none left pending", 32'(exp_q.size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
